// File: rtl/anton_neopixel_pixel_shifter.sv
// NeoPixel pixel shifter: holds the current 24-bit pixel, prefetches the next one
// from the pixel buffer and turns the stream timing indices into the serial waveform.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif

module anton_neopixel_pixel_shifter #(
  parameter  int unsigned BUFFER_END  = `BUFFER_END_DEFAULT,
  parameter  int unsigned T0H_TICKS   = 2,
  parameter  int unsigned T1H_TICKS   = 5,
  localparam int unsigned BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk6_4mhz,
  input  logic                   reset,
  input  logic                   regCtrl32bit,
  input  logic                   streamOutput,
  input  logic                   streamBitOf,
  input  logic [2:0]             bitPatternIndex,
  input  logic [4:0]             pixelBitIndex,
  input  logic [BUFFER_BITS-1:0] pixelIndex,
  input  logic [BUFFER_BITS-1:0] pixelIndexMax,
  output logic                   bufferReadEn,
  output logic [BUFFER_BITS-1:0] bufferReadAddr,
  input  logic [31:0]            bufferReadData,
  input  logic                   underflowClear,
  output logic                   neoData,
  output logic                   nextValid,
  output logic                   underflow
);

  typedef enum logic {LOAD, SHIFT} state_t;

  state_t                 state;
  logic [23:0]            cur_pixel;
  logic [23:0]            next_pixel;
  logic                   cur_valid;
  logic                   read_pending;

  logic [2:0]             red;
  logic [2:0]             green;
  logic [1:0]             blue;
  logic [23:0]            decoded;
  logic [23:0]            aligned;
  logic                   cur_bit;
  logic                   tick_high;
  logic                   load_capture;
  logic                   prefetch_tick;
  logic [BUFFER_BITS-1:0] index_equiv;
  logic [BUFFER_BITS-1:0] next_idx;
  logic                   unused_data_hi;

  assign unused_data_hi = ^bufferReadData[31:24];

  // Pixel decode, next-fetch address and current-bit waveform level.
  always_comb begin
    red           = bufferReadData[7:5];
    green         = bufferReadData[4:2];
    blue          = bufferReadData[1:0];
    decoded       = regCtrl32bit ? bufferReadData[23:0]
                  : {green, green, green[2:1], red, red, red[2:1], blue, blue, blue, blue};
    index_equiv   = regCtrl32bit ? {pixelIndex[BUFFER_BITS-1:2], 2'b11} : pixelIndex;
    next_idx      = (index_equiv == pixelIndexMax) ? '0
                  : pixelIndex + (regCtrl32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1));
    aligned       = cur_pixel << pixelBitIndex;
    cur_bit       = aligned[23];
    tick_high     = 32'(bitPatternIndex) < (cur_bit ? T1H_TICKS : T0H_TICKS);
    // A read without a pending prefetch is a LOAD-state refetch of the current pixel.
    load_capture  = bufferReadEn && !read_pending;
    prefetch_tick = (bitPatternIndex == 3'd0) && (pixelBitIndex == 5'd0);
  end

  always_ff @(posedge clk6_4mhz or posedge reset) begin
    if (reset) begin
      state          <= LOAD;
      neoData        <= 1'b0;
      bufferReadEn   <= 1'b0;
      bufferReadAddr <= '0;
      cur_pixel      <= '0;
      next_pixel     <= '0;
      cur_valid      <= 1'b0;
      nextValid      <= 1'b0;
      underflow      <= 1'b0;
      read_pending   <= 1'b0;
    end else begin
      if (underflowClear) underflow <= 1'b0;

      if (!streamOutput) begin
        // Idle: keep the current pixel loaded from the stream position; drop any prefetch.
        state          <= LOAD;
        bufferReadEn   <= 1'b1;
        bufferReadAddr <= pixelIndex;
        read_pending   <= 1'b0;
        nextValid      <= 1'b0;
        neoData        <= 1'b0;
        if (load_capture) begin
          cur_pixel <= decoded;
          cur_valid <= 1'b1;
        end
      end else begin
        state   <= SHIFT;
        neoData <= cur_valid && tick_high;

        if (load_capture) begin
          cur_pixel <= decoded;
          cur_valid <= 1'b1;
        end
        if (state == LOAD && !cur_valid && !load_capture) underflow <= 1'b1;

        if (prefetch_tick) begin
          bufferReadEn   <= 1'b1;
          bufferReadAddr <= next_idx;
          read_pending   <= 1'b1;
        end else begin
          bufferReadEn   <= 1'b0;
          read_pending   <= 1'b0;
        end

        if (read_pending) begin
          next_pixel <= decoded;
          nextValid  <= 1'b1;
        end

        // Pixel boundary: promote the prefetch, or transmit the next pixel dark.
        if (streamBitOf) begin
          if (nextValid) begin
            cur_pixel <= next_pixel;
            cur_valid <= 1'b1;
            nextValid <= 1'b0;
          end else begin
            cur_valid <= 1'b0;
            underflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_anton_neopixel_pixel_shifter.sv
// Bench for anton_neopixel_pixel_shifter: drives stream timing frame by frame and checks
// the serial waveform, prefetch addresses and underflow flag against a pixel-level model.
module tb_anton_neopixel_pixel_shifter;

  logic        clk6_4mhz = 1'b0;
  logic        reset = 1'b1;
  logic        regCtrl32bit = 1'b0;
  logic        streamOutput = 1'b0;
  logic        streamBitOf = 1'b0;
  logic [2:0]  bitPatternIndex = '0;
  logic [4:0]  pixelBitIndex = '0;
  logic [3:0]  pixelIndex = '0;
  logic [3:0]  pixelIndexMax = '0;
  logic        bufferReadEn;
  logic [3:0]  bufferReadAddr;
  logic [31:0] bufferReadData = '0;
  logic        underflowClear = 1'b0;
  logic        neoData;
  logic        nextValid;
  logic        underflow;

  logic [31:0] mem [16];
  int          checks = 0;
  int          errors = 0;

  anton_neopixel_pixel_shifter #(.BUFFER_END(15)) dut (
    .clk6_4mhz      (clk6_4mhz),
    .reset          (reset),
    .regCtrl32bit   (regCtrl32bit),
    .streamOutput   (streamOutput),
    .streamBitOf    (streamBitOf),
    .bitPatternIndex(bitPatternIndex),
    .pixelBitIndex  (pixelBitIndex),
    .pixelIndex     (pixelIndex),
    .pixelIndexMax  (pixelIndexMax),
    .bufferReadEn   (bufferReadEn),
    .bufferReadAddr (bufferReadAddr),
    .bufferReadData (bufferReadData),
    .underflowClear (underflowClear),
    .neoData        (neoData),
    .nextValid      (nextValid),
    .underflow      (underflow)
  );

  always #5 clk6_4mhz = ~clk6_4mhz;

  // Buffer: data for a strobed read is valid in the following cycle; garbage otherwise.
  always @(negedge clk6_4mhz)
    bufferReadData <= bufferReadEn ? mem[bufferReadAddr] : $urandom;

  function automatic logic [23:0] ref_decode(input logic [31:0] w, input bit m32);
    int r, g, b;
    if (m32) return w[23:0];
    r = int'((w >> 5) & 32'd7);
    g = int'((w >> 2) & 32'd7);
    b = int'(w & 32'd3);
    return 24'(((g * 36 + g / 2) << 16) | ((r * 36 + r / 2) << 8) | (b * 85));
  endfunction

  function automatic logic [3:0] ref_next(input logic [3:0] i, input logic [3:0] mx, input bit m32);
    if (m32) return ((i | 4'd3) == mx) ? 4'd0 : 4'((int'(i) + 4) % 16);
    return (i == mx) ? 4'd0 : 4'((int'(i) + 1) % 16);
  endfunction

  function automatic bit ref_level(input logic [23:0] pix, input int b, input int t);
    int v;
    v = int'((pix >> (23 - b)) & 24'd1);
    return t < (v != 0 ? 5 : 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk6_4mhz);
    #1;
  endtask

  task automatic load_phase(input logic [3:0] idx, input int n);
    streamOutput = 1'b0; streamBitOf = 1'b0;
    bitPatternIndex = '0; pixelBitIndex = '0; pixelIndex = idx;
    repeat (n) begin
      cycle();
      chk("load_en", 32'(bufferReadEn), 32'd1);
      chk("load_addr", 32'(bufferReadAddr), 32'(idx));
      chk("load_neo", 32'(neoData), 32'd0);
      chk("load_next_valid", 32'(nextValid), 32'd0);
    end
  endtask

  // One pixel of stream timing; dark = expect all-low; stop_bit < 24 ends after that bit's tick 0.
  task automatic tx_pixel(input logic [3:0] idx, input logic [23:0] pix, input logic [3:0] naddr,
                          input int stop_bit, input bit pulse, input bit dark);
    pixelIndex = idx;
    for (int b = 0; b < 24; b++) begin
      for (int t = 0; t < 8; t++) begin
        if (pulse && b == 12 && t == 0) begin
          streamOutput = 1'b0; streamBitOf = 1'b0;
          cycle();
          chk("pulse_neo", 32'(neoData), 32'd0);
          chk("pulse_next_valid", 32'(nextValid), 32'd0);
          chk("pulse_en", 32'(bufferReadEn), 32'd1);
          chk("pulse_addr", 32'(bufferReadAddr), 32'(idx));
        end
        streamOutput = 1'b1;
        pixelBitIndex = 5'(b);
        bitPatternIndex = 3'(t);
        streamBitOf = (b == 23 && t == 7);
        cycle();
        chk($sformatf("neo idx%0d b%0d t%0d", idx, b, t), 32'(neoData),
            dark ? 32'd0 : 32'(ref_level(pix, b, t)));
        if (b == 0 && t == 0) begin
          chk("prefetch_en", 32'(bufferReadEn), 32'd1);
          chk("prefetch_addr", 32'(bufferReadAddr), 32'(naddr));
        end
        if (b == 0 && t == 1) begin
          chk("prefetch_en_drop", 32'(bufferReadEn), 32'd0);
          chk("prefetch_valid", 32'(nextValid), 32'd1);
        end
        if (b == stop_bit) return;
      end
    end
    streamBitOf = 1'b0;
    chk("boundary_next_valid", 32'(nextValid), 32'd0);
  endtask

  task automatic run_frame(input bit m32, input logic [3:0] mx, input logic [3:0] start, input int npix);
    logic [3:0] idx, nidx;
    regCtrl32bit = m32; pixelIndexMax = mx;
    load_phase(start, 3);
    idx = start;
    for (int p = 0; p < npix; p++) begin
      nidx = ref_next(idx, mx, m32);
      tx_pixel(idx, ref_decode(mem[idx], m32), nidx, 24, 1'b0, 1'b0);
      idx = nidx;
    end
    chk("frame_underflow", 32'(underflow), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    // Reset state
    repeat (2) cycle();
    chk("rst_neo", 32'(neoData), 32'd0);
    chk("rst_en", 32'(bufferReadEn), 32'd0);
    chk("rst_addr", 32'(bufferReadAddr), 32'd0);
    chk("rst_next_valid", 32'(nextValid), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    reset = 1'b0;

    // Entering transmit with nothing loaded underflows; set beats a same-cycle clear
    streamOutput = 1'b1; underflowClear = 1'b1; pixelBitIndex = 5'd5; bitPatternIndex = 3'd3;
    cycle();
    chk("entry_underflow_set_wins", 32'(underflow), 32'd1);
    chk("entry_neo_dark", 32'(neoData), 32'd0);
    streamOutput = 1'b0; pixelBitIndex = '0; bitPatternIndex = '0;
    cycle();
    chk("underflow_cleared", 32'(underflow), 32'd0);
    underflowClear = 1'b0;

    // 32-bit mode, 0x00FF0000 with junk in the top byte
    mem[0] = {8'hA5, 24'hFF0000};
    regCtrl32bit = 1'b1; pixelIndexMax = 4'd3;
    load_phase(4'd0, 3);
    tx_pixel(4'd0, 24'hFF0000, 4'd0, 24, 1'b0, 1'b0);
    tx_pixel(4'd0, 24'hFF0000, 4'd0, 24, 1'b0, 1'b0);
    chk("t1_underflow", 32'(underflow), 32'd0);

    // 8-bit RGB332 byte 0xE3 expands to G=00 R=FF B=FF
    mem[0] = ($urandom & 32'hFFFF_FF00) | 32'h0000_00E3;
    regCtrl32bit = 1'b0; pixelIndexMax = 4'd0;
    load_phase(4'd0, 3);
    tx_pixel(4'd0, 24'h00FFFF, 4'd0, 24, 1'b0, 1'b0);
    tx_pixel(4'd0, 24'h00FFFF, 4'd0, 24, 1'b0, 1'b0);
    chk("t2_underflow", 32'(underflow), 32'd0);

    // 32-bit mode address wrap: index 4 with max 7 prefetches 0, then 0 prefetches 4
    regCtrl32bit = 1'b1; pixelIndexMax = 4'd7;
    load_phase(4'd4, 3);
    tx_pixel(4'd4, mem[4][23:0], 4'd0, 24, 1'b0, 1'b0);
    tx_pixel(4'd0, mem[0][23:0], 4'd4, 24, 1'b0, 1'b0);
    tx_pixel(4'd4, mem[4][23:0], 4'd0, 24, 1'b0, 1'b0);
    chk("t3_underflow", 32'(underflow), 32'd0);

    // Randomized frames in both modes; each frame starts at index 0 after a frame-end LOAD
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      run_frame(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'd0, int'($urandom_range(2, 4)));
    end

    // Prefetch discarded by a transmit dropout: underflow, next pixel dark, then recovery
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    regCtrl32bit = 1'b0; pixelIndexMax = 4'd3;
    load_phase(4'd0, 3);
    tx_pixel(4'd0, ref_decode(mem[0], 1'b0), 4'd1, 24, 1'b1, 1'b0);
    chk("dropout_underflow", 32'(underflow), 32'd1);
    tx_pixel(4'd1, 24'h0, 4'd2, 24, 1'b0, 1'b1);
    tx_pixel(4'd2, ref_decode(mem[2], 1'b0), 4'd3, 24, 1'b0, 1'b0);
    chk("underflow_sticky", 32'(underflow), 32'd1);
    underflowClear = 1'b1;
    load_phase(4'd0, 1);
    chk("underflow_clear", 32'(underflow), 32'd0);
    underflowClear = 1'b0;

    // Asynchronous reset in the middle of a pixel (bit 12, waveform high)
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    regCtrl32bit = 1'b1; pixelIndexMax = 4'd7;
    load_phase(4'd0, 3);
    tx_pixel(4'd0, mem[0][23:0], 4'd4, 12, 1'b0, 1'b0);
    chk("pre_reset_next_valid", 32'(nextValid), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_neo", 32'(neoData), 32'd0);
    chk("async_rst_next_valid", 32'(nextValid), 32'd0);
    chk("async_rst_en", 32'(bufferReadEn), 32'd0);
    cycle();
    reset = 1'b0;
    run_frame(1'b1, 4'd7, 4'd0, 2);
    run_frame(1'b0, 4'd2, 4'd0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_pixel_shifter.md
Name: anton_neopixel_pixel_shifter

Overview:
- Downstream consumer of the stream-timing logic.
- Fetches pixel data from the pixel buffer one pixel ahead of transmission and holds the current 24-bit pixel.
- Turns the timing indices (sub-bit pattern index, bit index) into the NeoPixel serial waveform (T0H = 2/8, T1H = 5/8 of a bit period at 6.4 MHz).
- Flags buffer underflow when prefetched data is not ready at a pixel boundary.

Parameters:
- BUFFER_END, `BUFFER_END_DEFAULT: last valid buffer index.
- BUFFER_BITS, `CLOG2(BUFFER_END+1) (localparam): pixel index width.
- T0H_TICKS, 2: sub-bit ticks driven high for a 0 bit.
- T1H_TICKS, 5: sub-bit ticks driven high for a 1 bit.

Ports:
- clk6_4mhz  in  1  stream clock.
- reset  in  1  asynchronous, active-high reset.
- regCtrl32bit  in  1  1 = 32-bit-per-pixel buffer mode; 0 = 8-bit RGB332 mode.
- streamOutput  in  1  stream logic is in transmit state.
- streamBitOf  in  1  last sub-bit tick of bit 23 of the current pixel.
- bitPatternIndex  in  3  sub-bit tick 0-7.
- pixelBitIndex  in  5  bit 0-23 of the current pixel.
- pixelIndex  in  BUFFER_BITS  index of the pixel being transmitted.
- pixelIndexMax  in  BUFFER_BITS  last reachable index.
- bufferReadEn  out  1  read strobe.
- bufferReadAddr  out  BUFFER_BITS  read index.
- bufferReadData  in  32  read data, valid exactly 1 cycle after bufferReadEn.
- underflowClear  in  1  clears the sticky underflow flag.
- neoData  out  1  registered serial output to the LED strip.
- nextValid  out  1  prefetched pixel is held.
- underflow  out  1  sticky underflow flag.

Behaviour:
- Reset (async): neoData=0, bufferReadEn=0, bufferReadAddr=0, curPixel=0, nextPixel=0, curValid=0, nextValid=0, underflow=0, state=LOAD, readPending=0.
- Pixel decode of captured data:
  - 32-bit mode: pixel = bufferReadData[23:0], bits [31:24] ignored.
  - 8-bit mode: byte = bufferReadData[7:0] = RRRGGGBB. Pixel = {g,g,g[2:1]} then {r,r,r[2:1]} then {b,b,b,b}, in GRB transmit order.
- nextIdx = (pixelIndexEquiv == pixelIndexMax) ? 0 : pixelIndex + (regCtrl32bit ? 4 : 1).
  - pixelIndexEquiv = {pixelIndex[BUFFER_BITS-1:2], 2'b11} in 32-bit mode, else pixelIndex.
  - Addition wraps modulo 2^BUFFER_BITS.
- State LOAD (streamOutput=0):
  - bufferReadEn=1 and bufferReadAddr=pixelIndex every cycle.
  - The cycle after each read: curPixel <= decoded data, curValid <= 1.
  - nextValid forced 0; neoData <= 0.
  - Transition to SHIFT when streamOutput rises.
- State SHIFT (streamOutput=1):
  - On the tick with bitPatternIndex==0 and pixelBitIndex==0: one-cycle bufferReadEn=1, bufferReadAddr=nextIdx, readPending<=1.
  - Next cycle: nextPixel <= decoded data, nextValid <= 1, readPending <= 0.
  - All other SHIFT cycles: bufferReadEn=0; bufferReadAddr holds its last value.
  - Current bit b = curPixel[23 - pixelBitIndex], MSB first.
  - Registered output: neoData <= curValid && (bitPatternIndex < (b ? T1H_TICKS : T0H_TICKS)).
  - Latency from index inputs to neoData is exactly 1 cycle.
  - On streamBitOf with nextValid=1: curPixel <= nextPixel, curValid <= 1, nextValid <= 0.
  - On streamBitOf with nextValid=0: underflow <= 1, curValid <= 0. The following pixel transmits all-low.
- Return to LOAD when streamOutput falls (end of frame or regCtrlRun/regCtrlInit deassert). Any pending read result is discarded. In LOAD, curPixel is re-loaded from pixelIndex, which the stream logic has wrapped to 0.
- Entry into SHIFT with curValid=0 sets underflow.
- underflow is sticky until underflowClear=1. If underflowClear and a new underflow occur in the same cycle, set wins.
- Changing regCtrl32bit mid-frame takes effect on the next fetch only; curPixel is not re-decoded.
- Single-pixel buffer (pixelIndexMax==0): nextIdx=0, the same pixel is refetched, no underflow.

Test Plan:
- 32-bit mode, buffer[0]=0x00FF0000, drive stream timing for pixel 0 → neoData high for 5 ticks on bits 0-7 and 2 ticks on bits 8-23; waveform delayed 1 cycle from the indices.
- 8-bit mode, byte 0xE3 (r=7, g=0, b=3) → transmitted pixel 0x00_FF_FF (G=0x00, R=0xFF, B=0xFF).
- 32-bit mode, pixelIndex=4, pixelIndexMax=7 → prefetch bufferReadAddr=0 at bit 0 tick 0; at pixelIndex=0, prefetch address=4.
- Read data withheld by forcing readPending result to be discarded via a streamOutput pulse, then streamBitOf with nextValid=0 → underflow=1 and the next pixel is all low. underflowClear → 0; simultaneous clear and new underflow → stays 1.
- Assert reset mid-pixel (pixelBitIndex=12) → neoData=0, curValid=0, nextValid=0 immediately, without waiting for a clock edge; after release, LOAD refetches pixelIndex.
- Frame end: streamOutput falls after the last pixel → bufferReadEn stays 1 with addr=pixelIndex=0 in LOAD; first pixel of the next frame transmits the correct data with no underflow.
